neo_pixel_strand_receiver: RTL and testbench

- Decodes a WS2812-style serial `neo_data` stream, as driven by the strand controller, back into 24-bit GRB pixel words and frame-latch events.
- Used as an on-chip loopback checker in strand benches and as a front end for daisy-chained receive boards.
- Measures each high pulse width to recover bits, assembles 24-bit pixels MSB-first, and flags the ≥50 µs low latch period as end of frame.

---
 rtl/neo_pixel_strand_receiver.sv | 178 +++++++++++++++++
 tb/tb_neo_pixel_strand_receiver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_pixel_strand_receiver.sv
// WS2812-style serial receiver: recovers bits from high-pulse widths, assembles
// 24-bit GRB pixels MSB-first and reports the end-of-frame latch period.
module neo_pixel_strand_receiver #(
    parameter int NUM_PIXELS   = 5,
    parameter int BIT_THRESH   = 26,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 100,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        neo_data,
    output logic [23:0] pixel_grb,
    output logic [2:0]  pixel_index,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [2:0]  frame_pixels,
    output logic        bit_error
);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [6:0]  HI_MAX   = 7'(MAX_HIGH);
    localparam logic [6:0]  HI_MIN   = 7'(MIN_HIGH);
    localparam logic [6:0]  HI_THR   = 7'(BIT_THRESH);
    localparam logic [11:0] LO_LATCH = 12'(LATCH_CYCLES);
    localparam logic [2:0]  PIX_MAX  = 3'(NUM_PIXELS);

    state_t      state, state_next;
    logic        sync1, sync2, data_d;
    logic [6:0]  hi_cnt, hi_next, hi_inc;
    logic [11:0] lo_cnt, lo_next, lo_inc;
    logic [4:0]  bit_cnt, bit_next;
    logic [2:0]  pix_cnt, pix_next;
    logic [23:0] shift_reg, shift_next, shifted;
    logic [23:0] grb_next;
    logic [2:0]  index_next, fpix_next;
    logic        valid_next, done_next, err_next;
    logic        rise, new_bit;

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            data_d       <= 1'b0;
            state        <= SYNC;
            hi_cnt       <= 7'd0;
            lo_cnt       <= 12'd0;
            bit_cnt      <= 5'd0;
            pix_cnt      <= 3'd0;
            shift_reg    <= 24'd0;
            pixel_grb    <= 24'd0;
            pixel_index  <= 3'd0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            frame_pixels <= 3'd0;
            bit_error    <= 1'b0;
        end else begin
            sync1        <= neo_data;
            sync2        <= sync1;
            data_d       <= sync2;
            state        <= state_next;
            hi_cnt       <= hi_next;
            lo_cnt       <= lo_next;
            bit_cnt      <= bit_next;
            pix_cnt      <= pix_next;
            shift_reg    <= shift_next;
            pixel_grb    <= grb_next;
            pixel_index  <= index_next;
            pixel_valid  <= valid_next;
            frame_done   <= done_next;
            frame_pixels <= fpix_next;
            bit_error    <= err_next;
        end
    end

    // Pulse-width decoding, pixel assembly and latch detection.
    always_comb begin
        rise       = sync2 & ~data_d;
        hi_inc     = (hi_cnt >= HI_MAX) ? HI_MAX : (hi_cnt + 7'd1);
        lo_inc     = (lo_cnt == 12'hFFF) ? lo_cnt : (lo_cnt + 12'd1);
        new_bit    = (hi_cnt > HI_THR);
        shifted    = {shift_reg[22:0], new_bit};
        state_next = state;
        hi_next    = hi_cnt;
        lo_next    = lo_cnt;
        bit_next   = bit_cnt;
        pix_next   = pix_cnt;
        shift_next = shift_reg;
        grb_next   = pixel_grb;
        index_next = pixel_index;
        valid_next = 1'b0;
        done_next  = 1'b0;
        fpix_next  = frame_pixels;
        err_next   = bit_error;

        case (state)
            SYNC: begin
                bit_next = 5'd0;
                pix_next = 3'd0;
                if (sync2) begin
                    lo_next = 12'd0;
                end else if (lo_inc == LO_LATCH) begin
                    lo_next    = 12'd0;
                    state_next = IDLE;
                end else begin
                    lo_next = lo_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    hi_next    = 7'd0;
                    state_next = HIGH;
                end else begin
                    state_next = IDLE;
                end
            end
            HIGH: begin
                if (sync2) begin
                    hi_next = hi_inc;
                    if (hi_inc == HI_MAX) begin
                        err_next   = 1'b1;
                        lo_next    = 12'd0;
                        state_next = SYNC;
                    end else begin
                        state_next = HIGH;
                    end
                end else if (hi_cnt < HI_MIN) begin
                    // Glitch: leave the low counter running from the last real bit.
                    state_next = LOW;
                end else begin
                    shift_next = shifted;
                    lo_next    = 12'd0;
                    state_next = LOW;
                    if (bit_cnt == 5'd23) begin
                        bit_next = 5'd0;
                        if (pix_cnt == PIX_MAX) begin
                            err_next = 1'b1;
                        end else begin
                            grb_next   = shifted;
                            index_next = pix_cnt;
                            valid_next = 1'b1;
                            pix_next   = pix_cnt + 3'd1;
                        end
                    end else begin
                        bit_next = bit_cnt + 5'd1;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    hi_next    = 7'd0;
                    state_next = HIGH;
                end else if (lo_inc == LO_LATCH) begin
                    lo_next    = lo_inc;
                    done_next  = 1'b1;
                    fpix_next  = pix_cnt;
                    bit_next   = 5'd0;
                    pix_next   = 3'd0;
                    err_next   = bit_error | (bit_cnt != 5'd0);
                    state_next = IDLE;
                end else begin
                    lo_next = lo_inc;
                end
            end
            default: begin
                state_next = SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_neo_pixel_strand_receiver.sv
// Directed bench for neo_pixel_strand_receiver: drives WS2812 waveforms and
// checks decoded pixels, frame latches and error flagging.
module tb_neo_pixel_strand_receiver;

    logic        clock;
    logic        reset;
    logic        neo_data;
    logic [23:0] pixel_grb;
    logic [2:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic [2:0]  frame_pixels;
    logic        bit_error;

    int checks;
    int failures;
    logic [23:0] grb_q[$];
    logic [2:0]  idx_q[$];
    int          done_cnt;
    logic [2:0]  fpix_seen;

    neo_pixel_strand_receiver dut (
        .clock        (clock),
        .reset        (reset),
        .neo_data     (neo_data),
        .pixel_grb    (pixel_grb),
        .pixel_index  (pixel_index),
        .pixel_valid  (pixel_valid),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .bit_error    (bit_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every pixel and latch event, sampled away from the active edge.
    always @(negedge clock) begin
        if (pixel_valid) begin
            grb_q.push_back(pixel_grb);
            idx_q.push_back(pixel_index);
        end
        if (frame_done) begin
            done_cnt  = done_cnt + 1;
            fpix_seen = frame_pixels;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic low_cycles(input int n);
        neo_data = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic high_cycles(input int n);
        neo_data = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            high_cycles(35);
            low_cycles(30);
        end else begin
            high_cycles(18);
            low_cycles(40);
        end
    endtask

    // Same timing, but with a 5-cycle glitch pulse inside the low gap.
    task automatic send_bit_glitch(input logic b);
        high_cycles(b ? 35 : 18);
        low_cycles(12);
        high_cycles(5);
        low_cycles(20);
    endtask

    task automatic send_pixel(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic clear_log();
        grb_q.delete();
        idx_q.delete();
        done_cnt = 0;
        fpix_seen = 3'd7;
    endtask

    task automatic do_reset();
        neo_data = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [23:0] five_words [0:4];

    initial begin
        checks    = 0;
        failures  = 0;
        done_cnt  = 0;
        fpix_seen = 3'd7;
        reset     = 1'b1;
        neo_data  = 1'b0;
        five_words[0] = 24'hFF0000;
        five_words[1] = 24'h00FF00;
        five_words[2] = 24'h0000FF;
        five_words[3] = 24'hFFFFFF;
        five_words[4] = 24'h000000;
        #1;
        chk("reset_grb", 32'(pixel_grb), 32'h0);
        chk("reset_idx", 32'(pixel_index), 32'h0);
        chk("reset_valid", 32'(pixel_valid), 32'h0);
        chk("reset_done", 32'(frame_done), 32'h0);
        chk("reset_fpix", 32'(frame_pixels), 32'h0);
        chk("reset_err", 32'(bit_error), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        clear_log();

        // Single pixel 0x123456 with the latency of the final bit checked.
        low_cycles(2520);
        for (int i = 23; i >= 1; i--) send_bit(1'(24'h123456 >> i));
        high_cycles(18);
        neo_data = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("lat_edge2_valid", 32'(pixel_valid), 32'h0);
        @(negedge clock);
        chk("lat_edge3_valid", 32'(pixel_valid), 32'h1);
        chk("lat_edge3_grb", 32'(pixel_grb), 32'h123456);
        low_cycles(2520);
        chk("p1_count", 32'(grb_q.size()), 32'd1);
        if (grb_q.size() > 0) begin
            chk("p1_grb", 32'(grb_q[0]), 32'h123456);
            chk("p1_idx", 32'(idx_q[0]), 32'd0);
        end
        chk("p1_done", 32'(done_cnt), 32'd1);
        chk("p1_fpix", 32'(fpix_seen), 32'd1);
        chk("p1_err", 32'(bit_error), 32'h0);

        // Two identical five-pixel frames; indices restart each frame.
        for (int f = 0; f < 2; f++) begin
            clear_log();
            for (int p = 0; p < 5; p++) send_pixel(five_words[p]);
            low_cycles(2520);
            chk("f5_count", 32'(grb_q.size()), 32'd5);
            for (int p = 0; p < 5; p++) begin
                if (p < grb_q.size()) begin
                    chk("f5_grb", 32'(grb_q[p]), 32'(five_words[p]));
                    chk("f5_idx", 32'(idx_q[p]), 32'(p));
                end
            end
            chk("f5_done", 32'(done_cnt), 32'd1);
            chk("f5_fpix", 32'(fpix_seen), 32'd5);
            chk("f5_err", 32'(bit_error), 32'h0);
        end

        // Glitch pulses between bits are ignored.
        clear_log();
        for (int i = 23; i >= 0; i--) send_bit_glitch(1'(24'hA5C3F0 >> i));
        low_cycles(2520);
        chk("gl_count", 32'(grb_q.size()), 32'd1);
        if (grb_q.size() > 0) chk("gl_grb", 32'(grb_q[0]), 32'hA5C3F0);
        chk("gl_fpix", 32'(fpix_seen), 32'd1);
        chk("gl_err", 32'(bit_error), 32'h0);

        // Six pixels: the sixth overflows.
        clear_log();
        for (int p = 0; p < 5; p++) send_pixel(24'h010203 + 24'(p));
        chk("ov_err_before", 32'(bit_error), 32'h0);
        send_pixel(24'hABCDEF);
        chk("ov_err_after", 32'(bit_error), 32'h1);
        chk("ov_grb_held", 32'(pixel_grb), 32'h010207);
        low_cycles(2520);
        chk("ov_count", 32'(grb_q.size()), 32'd5);
        chk("ov_fpix", 32'(fpix_seen), 32'd5);
        chk("ov_done", 32'(done_cnt), 32'd1);

        // Partial pixel at latch, then a clean frame.
        do_reset();
        chk("rs_err_clear", 32'(bit_error), 32'h0);
        low_cycles(2520);
        clear_log();
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        low_cycles(2520);
        chk("pp_count", 32'(grb_q.size()), 32'd0);
        chk("pp_done", 32'(done_cnt), 32'd1);
        chk("pp_fpix", 32'(fpix_seen), 32'd0);
        chk("pp_err", 32'(bit_error), 32'h1);
        clear_log();
        send_pixel(24'h89ABCD);
        low_cycles(2520);
        chk("pp_next_count", 32'(grb_q.size()), 32'd1);
        if (grb_q.size() > 0) begin
            chk("pp_next_grb", 32'(grb_q[0]), 32'h89ABCD);
            chk("pp_next_idx", 32'(idx_q[0]), 32'd0);
        end
        chk("pp_next_fpix", 32'(fpix_seen), 32'd1);

        // Over-long high pulse forces resynchronisation.
        do_reset();
        low_cycles(2520);
        clear_log();
        high_cycles(120);
        low_cycles(10);
        chk("lp_err", 32'(bit_error), 32'h1);
        send_pixel(24'h5A5A5A);
        low_cycles(2520);
        chk("lp_sync_count", 32'(grb_q.size()), 32'd0);
        chk("lp_sync_done", 32'(done_cnt), 32'd0);
        send_pixel(24'h5A5A5A);
        low_cycles(2520);
        chk("lp_next_count", 32'(grb_q.size()), 32'd1);
        if (grb_q.size() > 0) chk("lp_next_grb", 32'(grb_q[0]), 32'h5A5A5A);
        chk("lp_next_fpix", 32'(fpix_seen), 32'd1);

        // One-cycle reset in the middle of a pixel.
        clear_log();
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        neo_data = 1'b0;
        reset = 1'b1;
        #1;
        chk("mr_grb", 32'(pixel_grb), 32'h0);
        chk("mr_fpix", 32'(frame_pixels), 32'h0);
        chk("mr_err", 32'(bit_error), 32'h0);
        chk("mr_idx_valid_done", {29'd0, pixel_index}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        send_pixel(24'hC0FFEE);
        low_cycles(2520);
        chk("mr_nosync_count", 32'(grb_q.size()), 32'd0);
        chk("mr_nosync_done", 32'(done_cnt), 32'd0);
        send_pixel(24'h13579B);
        low_cycles(2520);
        chk("mr_next_count", 32'(grb_q.size()), 32'd1);
        if (grb_q.size() > 0) chk("mr_next_grb", 32'(grb_q[0]), 32'h13579B);
        chk("mr_next_fpix", 32'(fpix_seen), 32'd1);
        chk("mr_next_err", 32'(bit_error), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
